// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter that drives the select lines of a downstream 4:1 mux.
// Each grant is held until done, the request drops, or the hold limit is hit.
module mux_sel_arbiter #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] grant,
  output logic       s0,
  output logic       s1,
  output logic       valid
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_MAX - 1);

  state_t     state_q, state_d;
  logic [3:0] grant_q, grant_d;
  logic [1:0] sel_q,   sel_d;
  logic       valid_q, valid_d;
  logic [3:0] hold_q,  hold_d;
  logic [1:0] last_q,  last_d;

  logic [1:0] cand;
  logic [1:0] pick;
  logic       pick_found;
  logic       release_w;

  // Circular search starting one past the most recently granted channel.
  always_comb begin
    cand       = '0;
    pick       = '0;
    pick_found = 1'b0;
    for (int unsigned k = 1; k <= 4; k++) begin
      cand = last_q + 2'(k);
      if (!pick_found && req[cand]) begin
        pick       = cand;
        pick_found = 1'b1;
      end
    end
  end

  assign release_w = done || !req[sel_q] || (hold_q == HOLD_LAST);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    hold_d  = hold_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        valid_d = 1'b0;
        if (pick_found) begin
          state_d = BUSY;
          grant_d = 4'b0001 << pick;
          sel_d   = pick;
          valid_d = 1'b1;
          hold_d  = '0;
        end
      end
      BUSY: begin
        if (release_w) begin
          state_d = IDLE;
          grant_d = '0;
          valid_d = 1'b0;
          hold_d  = '0;
          last_d  = sel_q;
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      hold_q  <= '0;
      last_q  <= 2'd3;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
    end
  end

  assign grant = grant_q;
  assign s0    = sel_q[0];
  assign s1    = sel_q[1];
  assign valid = valid_q;

endmodule

// File: doc/mux_sel_arbiter.md
MUX_SEL_ARBITER -- requirements
Module: mux_sel_arbiter

Interface
REQ-001 The block SHALL have one parameter: HOLD_MAX, default 8, the maximum number of cycles a grant is held (legal range 1..15).
REQ-002 The block SHALL have the following ports:
  clk    input   1  clock; all state changes on the rising edge
  rst    input   1  synchronous, active-high reset
  req    input   4  request per mux channel (bit0=a, bit1=b, bit2=c, bit3=d)
  done   input   1  single-cycle release pulse from the consumer of the mux output
  grant  output  4  one-hot grant, registered
  s0     output  1  mux select LSB (channel index bit 0), registered
  s1     output  1  mux select MSB (channel index bit 1), registered
  valid  output  1  high while s1/s0 select a granted channel, registered
REQ-003 s1 and s0 SHALL connect directly to the s1 and s0 inputs of the downstream 4:1 mux; channel index = {s1,s0}.

Function
REQ-004 The FSM SHALL have exactly two states: IDLE and BUSY.
REQ-005 IDLE, req==0: the block SHALL stay in IDLE with grant=0, valid=0, and s1/s0 holding their last value.
REQ-006 IDLE, req!=0: the block SHALL select the first requesting channel in circular order starting at (last+1) mod 4, where last is the most recently granted index.
REQ-007 On the cycle after the IDLE grant decision, the block SHALL present grant=onehot(index), {s1,s0}=index and valid=1, and enter BUSY (one-cycle latency from req to valid).
REQ-008 BUSY: grant, s1, s0 and valid SHALL stay constant; changes on non-granted req bits SHALL be ignored.
REQ-009 A 4-bit hold counter SHALL clear on entry to BUSY and increment by 1 each BUSY cycle.
REQ-010 BUSY SHALL release when any of these holds: done=1; req[index]=0; the hold counter reaches HOLD_MAX-1.
REQ-011 On release, the block SHALL go to IDLE on the next edge with grant=0, valid=0, and last=index.
REQ-012 Every grant SHALL be followed by at least one IDLE cycle, so valid is low for at least one cycle between consecutive grants.
REQ-013 Simultaneous release causes (for example done and timeout together) SHALL produce a single release with identical behaviour.
REQ-014 A done pulse while in IDLE SHALL be ignored.
REQ-015 With all four req bits held high, grants SHALL rotate 0,1,2,3,0,... and no channel SHALL wait longer than 3 grants.
REQ-016 A single continuously-requesting channel SHALL be re-granted after each one-cycle IDLE gap.

Reset
REQ-017 When rst=1 at a rising edge, the block SHALL set: state=IDLE, grant=0, valid=0, s1=0, s0=0, hold counter=0, last=3 (so the first grant search starts at channel 0).
REQ-018 rst SHALL take priority over every other input, including during BUSY; a reset mid-grant SHALL drop valid and grant on that same edge.
REQ-019 No output SHALL change except on a rising edge of clk.

Verification
REQ-020 Reset then req=4'b1111 held with done=0 and HOLD_MAX=8 -> grants 0001,0010,0100,1000,0001, each valid for 8 cycles, separated by a 1-cycle valid=0 gap; {s1,s0}=0,1,2,3,0.
REQ-021 req=4'b0100 only, done pulsed 3 cycles after valid rises -> grant=0100, s1=1, s0=0; valid falls on the edge after done; regrant after one IDLE cycle.
REQ-022 Granted on channel 1, then req changes from 4'b0010 to 4'b1000 mid-BUSY -> release on the next edge; next grant=1000, {s1,s0}=3.
REQ-023 rst asserted on the 2nd BUSY cycle of a channel-2 grant -> next edge grant=0, valid=0, s1=s0=0; after rst drops with req=4'b0110, first grant=0010 (search starts at 0).
REQ-024 done pulsed in IDLE with req=0, and done together with timeout on the last hold cycle -> no state change in IDLE; exactly one release in BUSY; scoreboard confirms that the mux output equals the input selected by {s1,s0} whenever valid=1.
